// File: rtl/alu_sequencer.sv
// alu_sequencer: handshake-driven ALU controller with optional Debug_Interface scan and held result.
module alu_sequencer #(
    parameter int ALU_LAT = 1,
    parameter bit SCAN_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [3:0] Ain,
    output logic [3:0] Bin,
    output logic [2:0] ALUop,
    input  logic [3:0] ALUout,
    output logic [1:0] dsel,
    input  logic [7:0] dout,
    output logic       dbg_valid,
    output logic [1:0] dbg_sel,
    output logic [7:0] dbg_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, WAIT, SCAN, RESP} state_t;
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n, ain_n, bin_n, res_data_n;
    logic [2:0] aluop_n;
    logic [1:0] dsel_n, dbg_sel_n;
    logic [7:0] dbg_data_n;
    logic       dbg_valid_n, res_valid_n;
    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        ain_n       = Ain;
        bin_n       = Bin;
        aluop_n     = ALUop;
        dsel_n      = dsel;
        dbg_sel_n   = dbg_sel;
        dbg_data_n  = dbg_data;
        dbg_valid_n = 1'b0;
        res_valid_n = res_valid;
        res_data_n  = res_data;
        case (state)
            IDLE: if (cmd_valid) begin
                ain_n   = cmd_a;
                bin_n   = cmd_b;
                aluop_n = cmd_op;
                cnt_n   = LAT_M1;
                state_n = WAIT;
            end
            WAIT: if (cnt == 4'd0) begin
                res_data_n  = ALUout;
                dsel_n      = 2'd0;
                state_n     = SCAN_EN ? SCAN : RESP;
                res_valid_n = !SCAN_EN;
            end else begin
                cnt_n = cnt - 4'd1;
            end
            SCAN: begin
                dbg_data_n  = dout;
                dbg_sel_n   = dsel;
                dbg_valid_n = 1'b1;
                dsel_n      = dsel + 2'd1;
                res_valid_n = (dsel == 2'd3);
                state_n     = (dsel == 2'd3) ? RESP : SCAN;
            end
            RESP: if (res_ready) begin
                res_valid_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            Ain       <= '0;
            Bin       <= '0;
            ALUop     <= '0;
            dsel      <= '0;
            dbg_valid <= 1'b0;
            dbg_sel   <= '0;
            dbg_data  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            Ain       <= ain_n;
            Bin       <= bin_n;
            ALUop     <= aluop_n;
            dsel      <= dsel_n;
            dbg_valid <= dbg_valid_n;
            dbg_sel   <= dbg_sel_n;
            dbg_data  <= dbg_data_n;
            res_valid <= res_valid_n;
            res_data  <= res_data_n;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench with ALU/debug models and result/debug scoreboards for two configurations.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       cv0, cr0, dbgv0, rv0, rr0, busy0;
    logic [2:0] op0, ALUop0;
    logic [3:0] a0, b0, Ain0, Bin0, aluout0, rd0;
    logic [1:0] dsel0, dbgs0;
    logic [7:0] dout0, dbgd0;
    logic       cv1, cr1, dbgv1, rv1, rr1, busy1;
    logic [2:0] op1, ALUop1;
    logic [3:0] a1, b1, Ain1, Bin1, aluout1, rd1;
    logic [1:0] dsel1, dbgs1;
    logic [7:0] dout1, dbgd1;

    function automatic logic [3:0] alu_f(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        return (o == 3'd0) ? x + y : (o == 3'd1) ? x - y : x ^ y;
    endfunction
    function automatic logic [7:0] dbg_f(input logic [1:0] s, input logic [3:0] r, input logic [3:0] x,
                                         input logic [3:0] y, input logic [2:0] o);
        return (s == 2'd0) ? {4'h0, r} : (s == 2'd1) ? {4'h0, x} : (s == 2'd2) ? {4'h0, y} : {5'h0, o};
    endfunction
    assign aluout0 = alu_f(ALUop0, Ain0, Bin0);
    assign dout0   = dbg_f(dsel0, aluout0, Ain0, Bin0, ALUop0);
    assign aluout1 = alu_f(ALUop1, Ain1, Bin1);
    assign dout1   = dbg_f(dsel1, aluout1, Ain1, Bin1, ALUop1);

    alu_sequencer #(.ALU_LAT(1), .SCAN_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(cr0), .cmd_op(op0), .cmd_a(a0), .cmd_b(b0),
        .Ain(Ain0), .Bin(Bin0), .ALUop(ALUop0), .ALUout(aluout0), .dsel(dsel0), .dout(dout0),
        .dbg_valid(dbgv0), .dbg_sel(dbgs0), .dbg_data(dbgd0), .res_valid(rv0), .res_ready(rr0),
        .res_data(rd0), .busy(busy0));
    alu_sequencer #(.ALU_LAT(3), .SCAN_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(cv1), .cmd_ready(cr1), .cmd_op(op1), .cmd_a(a1), .cmd_b(b1),
        .Ain(Ain1), .Bin(Bin1), .ALUop(ALUop1), .ALUout(aluout1), .dsel(dsel1), .dout(dout1),
        .dbg_valid(dbgv1), .dbg_sel(dbgs1), .dbg_data(dbgd1), .res_valid(rv1), .res_ready(rr1),
        .res_data(rd1), .busy(busy1));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc0 = 0;
    int n_res0 = 0;
    logic [3:0] res_q0[$], res_q1[$];
    int         acc_q0[$], acc_q1[$];
    logic [9:0] dbg_q0[$];
    logic       rv0_d = 1'b0, rv1_d = 1'b0;
    logic [3:0] r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expectations are pushed at the negedge before an accepting edge and popped as outputs appear.
    always @(negedge clk) begin
        if (!rst) begin
            if (cv0 && cr0) begin
                r = alu_f(op0, a0, b0);
                res_q0.push_back(r);
                acc_q0.push_back(cyc + 1);
                for (int s = 0; s < 4; s++) dbg_q0.push_back({2'(s), dbg_f(2'(s), r, a0, b0, op0)});
                n_acc0++;
            end
            if (cv1 && cr1) begin
                res_q1.push_back(alu_f(op1, a1, b1));
                acc_q1.push_back(cyc + 1);
            end
            if (rv0 && !rv0_d) begin
                chk("lat0_pending", 32'(acc_q0.size() != 0), 1);
                if (acc_q0.size() != 0) chk("lat0", cyc - acc_q0.pop_front(), 5);
            end
            if (rv1 && !rv1_d) begin
                chk("lat1_pending", 32'(acc_q1.size() != 0), 1);
                if (acc_q1.size() != 0) chk("lat1", cyc - acc_q1.pop_front(), 3);
            end
            if (rv0 && rr0) begin
                chk("res0_pending", 32'(res_q0.size() != 0), 1);
                if (res_q0.size() != 0) chk("res0", rd0, res_q0.pop_front());
                n_res0++;
            end
            if (rv1 && rr1) begin
                chk("res1_pending", 32'(res_q1.size() != 0), 1);
                if (res_q1.size() != 0) chk("res1", rd1, res_q1.pop_front());
            end
            if (dbgv0) begin
                chk("dbg0_pending", 32'(dbg_q0.size() != 0), 1);
                if (dbg_q0.size() != 0) chk("dbg0", {dbgs0, dbgd0}, dbg_q0.pop_front());
            end
            if (busy1) chk("dbg1_quiet", dbgv1, 0);
        end
        rv0_d = rv0;
        rv1_d = rv1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send0(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        op0 = o; a0 = x; b0 = y; cv0 = 1'b1;
        step(1);
        cv0 = 1'b0;
    endtask
    task automatic send1(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        op1 = o; a1 = x; b1 = y; cv1 = 1'b1;
        step(1);
        cv1 = 1'b0;
    endtask
    task automatic wait_idle0();
        for (int i = 0; i < 60 && busy0; i++) step(1);
        chk("idle0_timeout", busy0, 0);
    endtask
    task automatic wait_idle1();
        for (int i = 0; i < 60 && busy1; i++) step(1);
        chk("idle1_timeout", busy1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int last;
        rst = 1'b1;
        {cv0, op0, a0, b0, rr0} = '0;
        {cv1, op1, a1, b1, rr1} = '0;
        rr0 = 1'b1;
        rr1 = 1'b1;
        step(3);
        chk("reset_u0", {Ain0, Bin0, ALUop0, dsel0, dbgv0, dbgs0, dbgd0, rv0, rd0, busy0, cr0}, 0);
        chk("reset_u1", {Ain1, Bin1, ALUop1, dsel1, dbgv1, dbgs1, dbgd1, rv1, rd1, busy1, cr1}, 0);
        rst = 1'b0;
        step(1);
        chk("ready_after_reset", cr0, 1);
        // Basic add, wrap-around add, and subtract through the scanning instance.
        send0(3'd0, 4'd5, 4'd3);
        wait_idle0();
        send0(3'd0, 4'd15, 4'd1);
        wait_idle0();
        send0(3'd1, 4'd2, 4'd5);
        wait_idle0();
        // Back-pressure: result must stay put and new commands must be ignored.
        rr0 = 1'b0;
        send0(3'd0, 4'd5, 4'd3);
        step(5);
        for (int i = 0; i < 10; i++) begin
            cv0 = 1'b1; op0 = 3'd1; a0 = 4'd9; b0 = 4'd9;
            chk("hold_valid", rv0, 1);
            chk("hold_data", rd0, 4'd8);
            chk("hold_ready", cr0, 0);
            step(1);
        end
        cv0 = 1'b0;
        rr0 = 1'b1;
        step(1);
        chk("release_idle", busy0, 0);
        chk("release_ready", cr0, 1);
        // Longer latency, no scan.
        send1(3'd0, 4'd7, 4'd6);
        step(2);
        chk("lat3_early", rv1, 0);
        step(1);
        chk("lat3_valid", rv1, 1);
        chk("lat3_data", rd1, 4'd13);
        wait_idle1();
        send1(3'd1, 4'd3, 4'd9);
        wait_idle1();
        // Reset in the middle of the debug scan.
        send0(3'd1, 4'd9, 4'd4);
        step(3);
        rst = 1'b1;
        step(1);
        chk("midscan_reset", {Ain0, Bin0, ALUop0, dsel0, dbgv0, dbgs0, dbgd0, rv0, rd0, busy0, cr0}, 0);
        res_q0.delete();
        acc_q0.delete();
        dbg_q0.delete();
        n_acc0 = 0;
        n_res0 = 0;
        rst = 1'b0;
        #1;
        chk("ready_after_midscan", cr0, 1);
        // Streaming: cmd_valid held high, new operands after every accept.
        step(1);
        cv0 = 1'b1;
        last = 0;
        for (int i = 0; i < 6; i++) begin
            for (int t = 0; t < 20 && !cr0; t++) step(1);
            chk("stream_ready", cr0, 1);
            op0 = 3'(i % 2); a0 = 4'(i * 3 + 1); b0 = 4'(i * 5 + 2);
            step(1);
            if (i > 0) chk("stream_spacing", cyc - last, 7);
            last = cyc;
        end
        cv0 = 1'b0;
        wait_idle0();
        step(2);
        chk("stream_count", n_res0, n_acc0);
        chk("stream_accepts", n_acc0, 6);
        chk("drained", res_q0.size() + res_q1.size() + dbg_q0.size() + acc_q0.size() + acc_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
